// File: rtl/alu_reg_integration_pkg.sv
// Shared definitions for the ALU + register-file tile.
//   DATA_W  : operand, result and register width
//   ADDR_W  : register address width (DEPTH = 2**ADDR_W entries)
//   alu_op_e: 2-bit ALU operation select encodings
package alu_reg_integration_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_NAND = 2'b10,
        OP_NOR  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_reg_integration_if.sv
// Bus bundle between the tile and whoever drives it.
//   we, A, B, opcode, write_addr : write-side controls and ALU operands
//   read_addr                    : asynchronous read address
//   read_data                    : contents of regs[read_addr]
// master modport: the driving side; slave modport: the tile.
interface alu_reg_integration_if;
    import alu_reg_integration_pkg::*;

    logic              we;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [1:0]        opcode;
    logic [ADDR_W-1:0] write_addr;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] read_data;

    modport master (
        output we, A, B, opcode, write_addr, read_addr,
        input  read_data
    );

    modport slave (
        input  we, A, B, opcode, write_addr, read_addr,
        output read_data
    );

endinterface

// File: rtl/alu_reg_integration_alu_logic8.sv
// Combinational bitwise logic unit, full DATA_W width, no carry or flags.
//   A, B   : operands
//   opcode : AND / OR / NAND / NOR select
//   result : selected bitwise function of A and B
module alu_logic8
    import alu_reg_integration_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [1:0]        opcode,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_op_e'(opcode))
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_NAND: result = ~(A & B);
            OP_NOR:  result = ~(A | B);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_reg_integration.sv
// Datapath tile: the ALU result is written into an 8-entry register file
// with one write port and one independent asynchronous read port.
//   clk : single clock, all state changes on the rising edge
//   rst : synchronous active-high reset, clears every entry, beats we
//   bus : slave side of alu_reg_integration_if (operands, write and read ports)
module alu_reg_integration
    import alu_reg_integration_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    alu_reg_integration_if.slave  bus
);

    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] regs [DEPTH];

    alu_logic8 u_alu (
        .A      (bus.A),
        .B      (bus.B),
        .opcode (bus.opcode),
        .result (alu_result)
    );

    // Reset takes priority: a write presented in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.we) begin
            regs[bus.write_addr] <= alu_result;
        end
    end

    // No write-through bypass: a same-address read shows the old value until the edge.
    assign bus.read_data = regs[bus.read_addr];

endmodule

// File: tb/tb_alu_reg_integration.sv
module tb_alu_reg_integration;
    import alu_reg_integration_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_reg_integration_if bif();

    alu_reg_integration dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [2:0] waddr;
        logic [7:0] expected;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] model [8];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 8; i++) model[i] = 8'h00;
        end else if (bif.we) begin
            model[bif.write_addr] = ref_alu(bif.A, bif.B, bif.opcode);
        end
    endtask

    task automatic sweep_model(input string name);
        for (int i = 0; i < 8; i++) begin
            bif.read_addr = 3'(i);
            #1;
            check(name, bif.read_data, model[i]);
        end
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < 8; i++) begin
            bif.read_addr = 3'(i);
            #1;
            check(name, bif.read_data, 8'h00);
        end
    endtask

    initial begin
        vecs[0] = '{8'h95, 8'h0F, 2'b00, 3'd1, 8'h05};
        vecs[1] = '{8'h6A, 8'h0F, 2'b01, 3'd2, 8'h6F};
        vecs[2] = '{8'h53, 8'h0F, 2'b10, 3'd3, 8'hFC};
        vecs[3] = '{8'hAC, 8'h0F, 2'b11, 3'd4, 8'h50};

        rst = 1'b1;
        bif.we = 1'b0;
        bif.A = '0;
        bif.B = '0;
        bif.opcode = '0;
        bif.write_addr = '0;
        bif.read_addr = '0;
        #2;

        // Reset: one edge, every entry reads 0
        edge_step();
        model_edge();
        rst = 1'b0;
        sweep_zero("reset_sweep");

        // Table-driven writes, each readable one edge later
        for (int v = 0; v < 4; v++) begin
            bif.A = vecs[v].a;
            bif.B = vecs[v].b;
            bif.opcode = vecs[v].op;
            bif.write_addr = vecs[v].waddr;
            bif.we = 1'b1;
            edge_step();
            model_edge();
            bif.we = 1'b0;
            bif.read_addr = vecs[v].waddr;
            #1;
            check("vector_write", bif.read_data, vecs[v].expected);
        end
        bif.read_addr = 3'd1;
        #1;
        check("entry1_kept", bif.read_data, 8'h05);

        // Hold: we=0 with fresh operands changes nothing
        bif.A = 8'hFF;
        bif.B = 8'h00;
        bif.opcode = 2'b01;
        bif.write_addr = 3'd1;
        bif.we = 1'b0;
        edge_step();
        model_edge();
        sweep_model("hold_we0");

        // Same-address read during write: old before the edge, new after
        bif.A = 8'hFF;
        bif.B = 8'h3C;
        bif.opcode = 2'b00;
        bif.write_addr = 3'd5;
        bif.we = 1'b1;
        edge_step();
        model_edge();
        bif.A = 8'h81;
        bif.B = 8'h42;
        bif.opcode = 2'b01;
        bif.read_addr = 3'd5;
        #1;
        check("rdw_before_edge", bif.read_data, 8'h3C);
        edge_step();
        model_edge();
        bif.we = 1'b0;
        check("rdw_after_edge", bif.read_data, 8'hC3);

        // Address 0 is an ordinary register
        bif.A = 8'hA5;
        bif.B = 8'h5A;
        bif.opcode = 2'b11;
        bif.write_addr = 3'd0;
        bif.we = 1'b1;
        edge_step();
        model_edge();
        bif.we = 1'b0;
        bif.read_addr = 3'd0;
        #1;
        check("addr0_write", bif.read_data, 8'h00);
        bif.opcode = 2'b10;
        bif.we = 1'b1;
        edge_step();
        model_edge();
        bif.we = 1'b0;
        #1;
        check("addr0_nand", bif.read_data, 8'hFF);

        // Priority: rst and we on the same edge -> all zero, write dropped
        bif.A = 8'hFF;
        bif.B = 8'hFF;
        bif.opcode = 2'b00;
        bif.write_addr = 3'd6;
        bif.we = 1'b1;
        rst = 1'b1;
        edge_step();
        model_edge();
        rst = 1'b0;
        bif.we = 1'b0;
        sweep_zero("rst_over_we");

        // Randomized traffic against the reference array
        for (int i = 0; i < 400; i++) begin
            bif.A = 8'($urandom);
            bif.B = 8'($urandom);
            bif.opcode = 2'($urandom);
            bif.write_addr = 3'($urandom);
            bif.read_addr = 3'($urandom);
            bif.we = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 24) == 0);
            #1;
            check("random_read", bif.read_data, model[bif.read_addr]);
            edge_step();
            model_edge();
        end
        rst = 1'b0;
        bif.we = 1'b0;
        sweep_model("random_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
